// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding, default timing constants and timer sizing for the PLL lock sequencer
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_t;

   localparam int DEF_RST_CYCLES   = 16;
   localparam int DEF_LOCK_TIMEOUT = 500000;
   localparam int DEF_LOCK_STABLE  = 1024;
   localparam int DEF_MAX_RETRIES  = 3;

   // One shared timer must hold the largest of the three per-state intervals.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer with selectable reset value
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor with bounded retries and core reset hold-off
// PLL_LOSS_COUNT_EN builds the saturating lock-loss counter on loss_cnt; otherwise loss_cnt is 0.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       seq_busy,
   output logic       pll_fail,
   output logic [1:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
   localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE - 1);
   localparam logic [1:0]    MAX_R    = 2'(MAX_RETRIES);

   pll_state_t    state, next_state;
   logic [TW-1:0] timer;
   logic          timer_clr, timer_run;
   logic [1:0]    retry_nxt;
   logic          lock_s;
   logic          pll_rst_nxt, core_rst_nxt, busy_nxt, fail_nxt;

   sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   always_comb begin
      next_state = state;
      retry_nxt  = retry_cnt;
      timer_clr  = 1'b0;
      timer_run  = 1'b0;
      case (state)
         PLL_RST: begin
            timer_run = 1'b1;
            if (timer == RST_LAST) next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            timer_run = 1'b1;
            if (lock_s) begin
               next_state = STABLE;
            end else if (timer == TO_LAST) begin
               if (retry_cnt < MAX_R) begin
                  retry_nxt  = retry_cnt + 2'd1;
                  next_state = PLL_RST;
               end else begin
                  next_state = FAIL;
               end
            end
         end
         STABLE: begin
            // Any dropout restarts the stability window without costing a retry.
            timer_run = 1'b1;
            if (!lock_s) begin
               timer_clr = 1'b1;
            end else if (timer == STB_LAST) begin
               next_state = RUN;
               retry_nxt  = 2'd0;
            end
         end
         RUN: begin
            if (!lock_s) next_state = PLL_RST;
         end
         FAIL: begin
         end
         default: next_state = PLL_RST;
      endcase

      if (relock_req) begin
         next_state = PLL_RST;
         retry_nxt  = 2'd0;
      end
      if ((next_state != state) || relock_req) timer_clr = 1'b1;

      pll_rst_nxt  = (next_state == PLL_RST) || (next_state == FAIL);
      core_rst_nxt = (next_state != RUN);
      busy_nxt     = (next_state != RUN) && (next_state != FAIL);
      fail_nxt     = (next_state == FAIL);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= PLL_RST;
         timer     <= '0;
         retry_cnt <= 2'd0;
         pll_rst   <= 1'b1;
         core_rst  <= 1'b1;
         seq_busy  <= 1'b1;
         pll_fail  <= 1'b0;
      end else begin
         state     <= next_state;
         retry_cnt <= retry_nxt;
         pll_rst   <= pll_rst_nxt;
         core_rst  <= core_rst_nxt;
         seq_busy  <= busy_nxt;
         pll_fail  <= fail_nxt;
         if (timer_clr)      timer <= '0;
         else if (timer_run) timer <= timer + TW'(1);
      end
   end

`ifdef PLL_LOSS_COUNT_EN
   logic       loss_evt;
   logic [7:0] loss_q;

   // A simultaneous relock request owns the transition, so it is not a loss.
   assign loss_evt = (state == RUN) && !lock_s && !relock_req;

   always_ff @(posedge refclk) begin
      if (rst)                             loss_q <= 8'd0;
      else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer against a behavioural model
module tb_pll_lock_sequencer;

   localparam int RST_C = 16;
   localparam int TO    = 100;
   localparam int STB   = 1024;
   localparam int MAXR  = 3;

   localparam int PH_RST    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_SETTLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAILED = 4;

`ifdef PLL_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic       refclk     = 1'b0;
   logic       rst        = 1'b1;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, core_rst, seq_busy, pll_fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [31:0] dut_v;

   int n_cmp = 0;
   int n_err = 0;

   int m_phase = 0;
   int m_el    = 0;
   int m_retry = 0;
   int m_loss  = 0;
   bit m_h1    = 1'b0;
   bit m_h2    = 1'b0;

   always #10 refclk = ~refclk;

   pll_lock_sequencer #(
      .RST_CYCLES   (RST_C),
      .LOCK_TIMEOUT (TO),
      .LOCK_STABLE  (STB),
      .MAX_RETRIES  (MAXR)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .core_rst   (core_rst),
      .seq_busy   (seq_busy),
      .pll_fail   (pll_fail),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   assign dut_v = {18'd0, pll_rst, core_rst, seq_busy, pll_fail, retry_cnt, loss_cnt};

   // Behavioural reference: phase plus cycles-in-phase, lock seen two samples late.
   always @(posedge refclk) begin : model
      bit ls;
      int np;
      ls = m_h2;
      if (rst) begin
         m_phase = PH_RST;
         m_el    = 0;
         m_retry = 0;
         m_loss  = 0;
         m_h1    = 1'b0;
         m_h2    = 1'b0;
      end else begin
         m_h2 = m_h1;
         m_h1 = pll_locked;
         np   = m_phase;
         m_el++;
         case (m_phase)
            PH_RST:    if (m_el == RST_C) np = PH_WAIT;
            PH_WAIT: begin
               if (ls) np = PH_SETTLE;
               else if (m_el == TO) begin
                  if (m_retry < MAXR) begin
                     m_retry++;
                     np = PH_RST;
                  end else begin
                     np = PH_FAILED;
                  end
               end
            end
            PH_SETTLE: begin
               if (!ls) m_el = 0;
               else if (m_el == STB) begin
                  np      = PH_RUN;
                  m_retry = 0;
               end
            end
            PH_RUN: begin
               if (!ls && !relock_req) begin
                  np = PH_RST;
                  if (LOSS_EN && m_loss < 255) m_loss++;
               end
            end
            default: ;
         endcase
         if (relock_req) begin
            np      = PH_RST;
            m_retry = 0;
         end
         if (np != m_phase || relock_req) m_el = 0;
         m_phase = np;
      end
   end

   function automatic logic [31:0] model_vec();
      logic [31:0] v;
      v       = '0;
      v[13]   = (m_phase == PH_RST) || (m_phase == PH_FAILED);
      v[12]   = (m_phase != PH_RUN);
      v[11]   = (m_phase == PH_RST) || (m_phase == PH_WAIT) || (m_phase == PH_SETTLE);
      v[10]   = (m_phase == PH_FAILED);
      v[9:8]  = 2'(m_retry);
      v[7:0]  = 8'(m_loss);
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge refclk);
      check("outs", dut_v, model_vec());
   endtask

   initial begin
      int t_prf, t_crf, n_pulse, cur, wmin, wmax, rseq, t, got2, len, found;

      rst = 1'b1;
      tick();
      tick();
      check("rst_vals", dut_v, 32'h0000_3800);
      rst = 1'b0;

      // Power-up lock with pll_locked rising at cycle 5
      t_prf = -1;
      t_crf = -1;
      for (int i = 1; i <= 3000 && t_crf < 0; i++) begin
         tick();
         if (i == 5) pll_locked = 1'b1;
         if (t_prf < 0 && !pll_rst)  t_prf = i;
         if (t_crf < 0 && !core_rst) t_crf = i;
      end
      check("pll_rst_fall", t_prf, RST_C);
      check("core_rst_window", (t_crf >= RST_C + 1 + STB) && (t_crf <= RST_C + 3 + STB), 1);
      check("run_busy", seq_busy, 0);
      check("run_retry", retry_cnt, 0);

      // No lock: bounded retries then fail
      pll_locked = 1'b0;
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n_pulse = 1;
      cur     = 1;
      rseq    = retry_cnt;
      wmin    = 999;
      wmax    = 0;
      for (int i = 0; i < 2000 && !pll_fail; i++) begin
         tick();
         if (pll_rst && !pll_fail) begin
            if (cur == 0) begin
               n_pulse++;
               rseq = rseq * 4 + retry_cnt;
            end
            cur++;
         end else if (cur > 0) begin
            if (cur < wmin) wmin = cur;
            if (cur > wmax) wmax = cur;
            cur = 0;
         end
      end
      check("fail_pulses", n_pulse, 4);
      check("fail_wmin", wmin, RST_C);
      check("fail_wmax", wmax, RST_C);
      check("fail_retry_seq", rseq, 27);
      repeat (5) tick();
      check("fail_hold", {pll_rst, pll_fail}, 2'b11);

      // Relock out of fail, then a 3-cycle dropout mid-stabilisation
      relock_req = 1'b1;
      pll_locked = 1'b1;
      tick();
      relock_req = 1'b0;
      check("relock_retry", retry_cnt, 0);
      check("relock_state", {pll_rst, pll_fail}, 2'b10);
      t = -1;
      for (int i = 1; i <= 100 && t < 0; i++) begin
         tick();
         if (!pll_rst) t = i;
      end
      check("relock_pll_rst_fall", t, RST_C);
      repeat (501) tick();
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      t = -1;
      for (int i = 1; i <= 1200 && t < 0; i++) begin
         tick();
         if (!core_rst) t = i;
      end
      check("glitch_restart", t, STB + 2);
      check("glitch_retry", retry_cnt, 0);

      // One-cycle lock loss in RUN
      repeat (3) tick();
      pll_locked = 1'b0;
      found = -1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 1) pll_locked = 1'b1;
         if (found < 0 && core_rst && pll_rst) found = i;
      end
      check("loss_react", found > 0, 1);
      check("loss_cnt1", loss_cnt, LOSS_EN ? 1 : 0);
      found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         tick();
         if (!core_rst) found = 1;
      end
      check("loss_rerun", found, 1);

      // Relock request coinciding with lock_s falling in RUN
      repeat (4) tick();
      pll_locked = 1'b0;
      tick();
      tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("relock_loss_state", {pll_rst, core_rst}, 2'b11);
      check("relock_loss_cnt", loss_cnt, LOSS_EN ? 1 : 0);

      // Reset in WAIT_LOCK after two failed attempts
      got2 = 0;
      for (int i = 0; i < 1000 && !got2; i++) begin
         tick();
         if (retry_cnt == 2'd2) got2 = 1;
      end
      check("retry2_reached", got2, 1);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (!pll_rst) found = 1;
      end
      check("retry2_wait", found, 1);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check("rst_mid", dut_v, 32'h0000_3800);
      rst = 1'b0;

      // Randomised lock behaviour with sparse relock requests and resets
      for (int seg = 0; seg < 40; seg++) begin
         pll_locked = ($urandom_range(0, 3) != 0);
         len = pll_locked ? $urandom_range(200, 1600) : $urandom_range(1, 150);
         for (int j = 0; j < len; j++) begin
            relock_req = ($urandom_range(0, 999) == 0);
            rst        = ($urandom_range(0, 4999) == 0);
            tick();
         end
      end
      relock_req = 1'b0;
      rst        = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
